// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state
// encoding, Booth operation codes and the default datapath width.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit and the bit
    // shifted out on the previous step.
    function automatic booth_op_t booth_decode(input logic lsb, input logic prev);
        case ({lsb, prev})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/ready handshake and operand/result bus of the multicycle multiplier.
// The master side issues operations; the slave side is the multiplier.
interface booth_mult_seq_if #(parameter int WIDTH = 32);

    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_mult, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_mult, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then a 1-bit arithmetic right shift of {acc, mq, q_1}.
// The accumulator carries one guard bit so the most negative multiplicand
// cannot overflow it.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mq,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] mq_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    // Add, subtract or pass the multiplicand according to the recoded bit pair.
    always_comb begin
        sum = acc;
        case (booth_decode(mq[0], q_1))
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
    end

    assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
    assign mq_next  = {sum[0], mq[WIDTH-1:1]};
    assign q_1_next = mq[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier for the execute stage. One Booth step per
// clock for WIDTH clocks, then a single-cycle DONE state that presents the
// low WIDTH product bits and an overflow flag. CNT_W must satisfy
// 2**CNT_W > WIDTH.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    booth_mult_seq_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             q_1;
    logic [WIDTH-1:0] result_reg;
    logic             exception_reg;
    logic             ready_reg;
    logic             busy_reg;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mq_next;
    logic             q_1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mq       (mq),
        .q_1      (q_1),
        .m        (m_reg),
        .acc_next (acc_next),
        .mq_next  (mq_next),
        .q_1_next (q_1_next)
    );

    // Control FSM plus datapath and output registers; the result and
    // overflow flag are only written on entry to DONE so they persist
    // across later starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            m_reg         <= '0;
            acc           <= '0;
            mq            <= '0;
            q_1           <= 1'b0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ready_reg <= 1'b0;
                    if (bus.ctrl_mult) begin
                        m_reg    <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
                        acc      <= '0;
                        mq       <= bus.data_operandB;
                        q_1      <= 1'b0;
                        cnt      <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    mq  <= mq_next;
                    q_1 <= q_1_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_reg    <= mq_next;
                        exception_reg <= (acc_next != {(WIDTH+1){mq_next[WIDTH-1]}});
                        ready_reg     <= 1'b1;
                        busy_reg      <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exception_reg;
    assign bus.data_resultRDY = ready_reg;
    assign bus.busy           = busy_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed testbench for booth_mult_seq: hand-computed products, latency,
// ignored restarts, mid-run reset and back-to-back operation.
module tb_booth_mult_seq;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    booth_mult_seq_if #(.WIDTH(32)) bus_if ();

    booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse ctrl_mult for one edge with the given operands; returns at the
    // falling edge just after the start edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus_if.data_operandA = a;
        bus_if.data_operandB = b;
        bus_if.ctrl_mult     = 1'b1;
        @(negedge clock);
        bus_if.ctrl_mult     = 1'b0;
    endtask

    // Count falling edges until data_resultRDY rises, bounded to 100.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (bus_if.data_resultRDY !== 1'b1 && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    // Full operation: start, wait, check latency, result, flag, pulse width.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_result, input logic exp_exc);
        int cycles;
        apply_stimulus(a, b);
        check_output({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
        wait_ready(cycles);
        check_output({tag, "_latency"}, 64'(cycles), 64'd32);
        check_output({tag, "_result"}, 64'(bus_if.data_result), 64'(exp_result));
        check_output({tag, "_exception"}, 64'(bus_if.data_exception), 64'(exp_exc));
        @(negedge clock);
        check_output({tag, "_rdy_pulse"}, 64'(bus_if.data_resultRDY), 64'd0);
    endtask

    // Directed sequence of steps.
    initial begin
        int cycles;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.ctrl_mult     = 1'b0;
        bus_if.data_operandA = '0;
        bus_if.data_operandB = '0;
        repeat (2) @(negedge clock);
        check_output("reset_result", 64'(bus_if.data_result), 64'd0);
        check_output("reset_exception", 64'(bus_if.data_exception), 64'd0);
        check_output("reset_rdy", 64'(bus_if.data_resultRDY), 64'd0);
        check_output("reset_busy", 64'(bus_if.busy), 64'd0);
        reset = 1'b0;

        run_op("mul_6x7", 32'd6, 32'd7, 32'h0000_002A, 1'b0);
        run_op("mul_m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);
        run_op("mul_min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("mul_min_x_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run_op("mul_2p16_sq", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_zero", 32'd0, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op("mul_m7xm9", 32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'h0000_003F, 1'b0);

        // Restart during RUN must be ignored, operand changes too.
        apply_stimulus(32'd12, 32'd12);
        repeat (4) @(negedge clock);
        bus_if.data_operandA = 32'd3;
        bus_if.data_operandB = 32'd5;
        bus_if.ctrl_mult     = 1'b1;
        @(negedge clock);
        bus_if.ctrl_mult     = 1'b0;
        wait_ready(cycles);
        check_output("ignore_latency", 64'(cycles + 5), 64'd32);
        check_output("ignore_result", 64'(bus_if.data_result), 64'd144);
        @(negedge clock);

        // Reset in the middle of an operation aborts it.
        apply_stimulus(32'd9, 32'd9);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("abort_busy", 64'(bus_if.busy), 64'd0);
        check_output("abort_rdy", 64'(bus_if.data_resultRDY), 64'd0);
        check_output("abort_result", 64'(bus_if.data_result), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("after_reset_2x3", 32'd2, 32'd3, 32'd6, 1'b0);

        // Back-to-back: restart during the DONE cycle.
        apply_stimulus(32'd100, 32'hFFFF_FFFE);
        wait_ready(cycles);
        check_output("b2b_first_latency", 64'(cycles), 64'd32);
        check_output("b2b_first_result", 64'(bus_if.data_result), 64'hFFFF_FF38);
        bus_if.data_operandA = 32'd7;
        bus_if.data_operandB = 32'd7;
        bus_if.ctrl_mult     = 1'b1;
        @(negedge clock);
        bus_if.ctrl_mult     = 1'b0;
        check_output("b2b_no_idle_busy", 64'(bus_if.busy), 64'd1);
        check_output("b2b_result_held", 64'(bus_if.data_result), 64'hFFFF_FF38);
        wait_ready(cycles);
        check_output("b2b_spacing", 64'(cycles + 1), 64'd33);
        check_output("b2b_second_result", 64'(bus_if.data_result), 64'd49);
        check_output("b2b_second_exception", 64'(bus_if.data_exception), 64'd0);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
